// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: issues IMEM requests at the current PC,
// absorbs wait states, buffers one instruction while decode is stalled,
// and drains wrong-path requests after a flush.
module inst_fetch_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] pc,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        id_stall,
  input  logic        flush,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_addr_q;
  logic [XLEN-1:0]   r_skid_inst;
  logic [XLEN-1:0]   r_skid_pc;
  logic              r_skid_valid;
  logic [XLEN-1:0]   r_if_inst;
  logic [XLEN-1:0]   r_if_pc;
  logic              r_if_valid;
  logic              w_take;

  assign if_inst  = r_if_inst;
  assign if_pc    = r_if_pc;
  assign if_valid = r_if_valid;
  assign w_take   = imem_req & imem_ack;

  // Memory request channel: address is live PC on the first attempt, then pinned
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_addr_q;
    case (r_state)
      S_FETCH: begin
        imem_req  = ~id_stall;
        imem_addr = pc;
      end
      S_WAIT, S_DRAIN: imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // PC advances on a redirect or when a real (non-drain) fetch is accepted
  always_comb begin
    pc_stall = 1'b1;
    if (clrn) begin
      if (flush) begin
        pc_stall = 1'b0;
      end else if (w_take && (r_state == S_FETCH || r_state == S_WAIT)) begin
        pc_stall = 1'b0;
      end
    end
  end

  // Control FSM together with the IF/ID output, skid and pinned-address registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_addr_q     <= '0;
      r_skid_inst  <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
      r_if_inst    <= '0;
      r_if_pc      <= '0;
      r_if_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          if (flush) begin
            r_if_inst    <= '0;
            r_if_pc      <= '0;
            r_if_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
          end
        end

        S_FETCH: begin
          if (flush) begin
            r_if_inst    <= '0;
            r_if_pc      <= '0;
            r_if_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
              r_addr_q <= pc;
              r_state  <= S_DRAIN;
            end
          end else if (!id_stall) begin
            if (imem_ack) begin
              r_if_inst  <= imem_rdata;
              r_if_pc    <= pc;
              r_if_valid <= 1'b1;
            end else begin
              r_if_inst  <= '0;
              r_if_pc    <= '0;
              r_if_valid <= 1'b0;
              r_addr_q   <= pc;
              r_state    <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (flush) begin
            r_if_inst    <= '0;
            r_if_pc      <= '0;
            r_if_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_state      <= imem_ack ? S_FETCH : S_DRAIN;
          end else if (imem_ack) begin
            if (!id_stall) begin
              r_if_inst  <= imem_rdata;
              r_if_pc    <= r_addr_q;
              r_if_valid <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_skid_inst  <= imem_rdata;
              r_skid_pc    <= r_addr_q;
              r_skid_valid <= 1'b1;
              r_state      <= S_HOLD;
            end
          end else if (!id_stall) begin
            r_if_inst  <= '0;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (flush) begin
            r_if_inst    <= '0;
            r_if_pc      <= '0;
            r_if_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
          end else if (!id_stall) begin
            r_if_inst    <= r_skid_inst;
            r_if_pc      <= r_skid_pc;
            r_if_valid   <= r_skid_valid;
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end

        S_DRAIN: begin
          r_if_inst    <= '0;
          r_if_pc      <= '0;
          r_if_valid   <= 1'b0;
          r_skid_valid <= 1'b0;
          if (imem_ack) begin
            r_state <= S_FETCH;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus a randomized run against
// an in-order instruction-stream model and a variable-latency memory.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        clrn;
  logic [31:0] pc;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        id_stall;
  logic        flush;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;

  int errors;
  int checks;

  logic        c_req;
  logic        c_stall;
  logic [31:0] c_addr;

  // random-run memory and stream model state
  bit          m_busy;
  logic [31:0] m_addr;
  int          m_lat;
  logic [31:0] exp_pc;
  int          n_cons;

  inst_fetch_ctrl dut (
    .clk        (clk),
    .clrn       (clrn),
    .pc         (pc),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .id_stall   (id_stall),
    .flush      (flush),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: distinct, nonzero word for every address
  function automatic logic [31:0] f_mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Drive one cycle of inputs, capture combinational outputs before the edge
  task automatic step(input logic st, input logic fl, input logic ak, input logic [31:0] rd);
    id_stall = st; flush = fl; imem_ack = ak; imem_rdata = rd;
    #1;
    c_req = imem_req; c_addr = imem_addr; c_stall = pc_stall;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; pc = 32'h1234; id_stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    #2;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %0b want 0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL rst_if_inst: got %h want 0", if_inst); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %0b want 0", imem_req); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rst_pc_stall: got %0b want 1", pc_stall); end
    @(posedge clk); #1;
    clrn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %0b want 0", c_req); end
    checks++; if (c_stall !== 1'b1) begin errors++; $display("FAIL idle_pc_stall: got %0b want 1", c_stall); end
  endtask

  task automatic test_zero_wait();
    pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, f_mem(pc));
      checks++; if (c_req !== 1'b1 || c_addr !== pc) begin errors++; $display("FAIL zw_req[%0d]: got req=%0b addr=%h want req=1 addr=%h", i, c_req, c_addr, pc); end
      checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL zw_pc_stall[%0d]: got %0b want 0", i, c_stall); end
      checks++; if (if_valid !== 1'b1 || if_pc !== pc || if_inst !== f_mem(pc)) begin errors++; $display("FAIL zw_out[%0d]: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h", i, if_valid, if_pc, if_inst, pc, f_mem(pc)); end
      pc = pc + 32'd4;
    end
  endtask

  task automatic test_wait_states();
    pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (c_req !== 1'b1 || c_addr !== 32'h40) begin errors++; $display("FAIL ws_addr[%0d]: got req=%0b addr=%h want req=1 addr=40", i, c_req, c_addr); end
      checks++; if (c_stall !== 1'b1) begin errors++; $display("FAIL ws_pc_stall[%0d]: got %0b want 1", i, c_stall); end
      checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL ws_bubble[%0d]: got v=%0b inst=%h want v=0 inst=0", i, if_valid, if_inst); end
    end
    step(1'b0, 1'b0, 1'b1, 32'h8C220000);
    checks++; if (c_stall !== 1'b0 || c_addr !== 32'h40) begin errors++; $display("FAIL ws_ack: got stall=%0b addr=%h want stall=0 addr=40", c_stall, c_addr); end
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h8C220000 || if_pc !== 32'h40) begin errors++; $display("FAIL ws_out: got v=%0b inst=%h pc=%h want v=1 inst=8c220000 pc=40", if_valid, if_inst, if_pc); end
    pc = 32'h44;
  endtask

  task automatic test_stall_in_wait();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'hCAFE0044);
    checks++; if (c_req !== 1'b1 || c_stall !== 1'b0) begin errors++; $display("FAIL siw_ack: got req=%0b stall=%0b want req=1 stall=0", c_req, c_stall); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL siw_frozen: got v=%0b want 0", if_valid); end
    pc = 32'h48;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (c_req !== 1'b0 || c_stall !== 1'b1) begin errors++; $display("FAIL hold_ctl[%0d]: got req=%0b stall=%0b want req=0 stall=1", i, c_req, c_stall); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hold_out[%0d]: got v=%0b want 0", i, if_valid); end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (c_stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall: got %0b want 1", c_stall); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_inst !== 32'hCAFE0044) begin errors++; $display("FAIL hold_release: got v=%0b pc=%h inst=%h want v=1 pc=44 inst=cafe0044", if_valid, if_pc, if_inst); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (c_addr !== 32'h48 || if_valid !== 1'b0) begin errors++; $display("FAIL hold_once: got addr=%h v=%0b want addr=48 v=0", c_addr, if_valid); end
    step(1'b0, 1'b0, 1'b1, f_mem(32'h48));
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h48) begin errors++; $display("FAIL hold_next: got v=%0b pc=%h want v=1 pc=48", if_valid, if_pc); end
    pc = 32'h4C;
  endtask

  task automatic test_flush_drain();
    pc = 32'h10;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (c_req !== 1'b1 || c_addr !== 32'h10 || c_stall !== 1'b0) begin errors++; $display("FAIL fl_cycle: got req=%0b addr=%h stall=%0b want req=1 addr=10 stall=0", c_req, c_addr, c_stall); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fl_bubble: got v=%0b want 0", if_valid); end
    pc = 32'h80;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (c_req !== 1'b1 || c_addr !== 32'h10 || c_stall !== 1'b1) begin errors++; $display("FAIL drain_hold[%0d]: got req=%0b addr=%h stall=%0b want req=1 addr=10 stall=1", i, c_req, c_addr, c_stall); end
    end
    step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    checks++; if (c_addr !== 32'h10 || c_stall !== 1'b1) begin errors++; $display("FAIL drain_ack: got addr=%h stall=%0b want addr=10 stall=1", c_addr, c_stall); end
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL drain_discard: got v=%0b inst=%h want v=0 inst=0", if_valid, if_inst); end
    step(1'b0, 1'b0, 1'b1, f_mem(32'h80));
    checks++; if (c_addr !== 32'h80 || c_stall !== 1'b0) begin errors++; $display("FAIL redirect_fetch: got addr=%h stall=%0b want addr=80 stall=0", c_addr, c_stall); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_inst !== f_mem(32'h80)) begin errors++; $display("FAIL redirect_out: got v=%0b pc=%h inst=%h want v=1 pc=80", if_valid, if_pc, if_inst); end
    pc = 32'h84;
  endtask

  task automatic test_flush_stall_ack();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'hBADBAD00);
    checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL fsa_stall: got %0b want 0", c_stall); end
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL fsa_out: got v=%0b inst=%h want v=0 inst=0", if_valid, if_inst); end
    pc = 32'h200;
    step(1'b0, 1'b0, 1'b1, f_mem(32'h200));
    checks++; if (c_req !== 1'b1 || c_addr !== 32'h200) begin errors++; $display("FAIL fsa_state: got req=%0b addr=%h want req=1 addr=200", c_req, c_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL fsa_next: got v=%0b pc=%h want v=1 pc=200", if_valid, if_pc); end
    pc = 32'h204;
  endtask

  task automatic test_reset_mid_wait();
    // live valid outputs must clear without a clock edge
    #1; clrn = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL arst_live: got v=%0b pc=%h inst=%h want 0", if_valid, if_pc, if_inst); end
    @(posedge clk); #1; clrn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    pc = 32'h300;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    id_stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL arst_pre_req: got %0b want 1", imem_req); end
    #1; clrn = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL arst_wait: got req=%0b stall=%0b want req=0 stall=1", imem_req, pc_stall); end
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL arst_wait_out: got v=%0b pc=%h inst=%h want 0", if_valid, if_pc, if_inst); end
    @(posedge clk); #1; clrn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (c_req !== 1'b0 || c_stall !== 1'b1) begin errors++; $display("FAIL arst_idle: got req=%0b stall=%0b want req=0 stall=1", c_req, c_stall); end
    step(1'b0, 1'b0, 1'b1, f_mem(32'h300));
    checks++; if (c_req !== 1'b1 || c_addr !== 32'h300) begin errors++; $display("FAIL arst_restart: got req=%0b addr=%h want req=1 addr=300", c_req, c_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300) begin errors++; $display("FAIL arst_restart_out: got v=%0b pc=%h want v=1 pc=300", if_valid, if_pc); end
  endtask

  // One randomized cycle: memory answers after 0..3 cycles, decode consumes in order
  task automatic rand_cycle(input bit chaos);
    logic        st, fl, pv, pstall;
    logic [31:0] ppc, pinst, tgt;
    st  = chaos && ($urandom_range(0, 3) == 0);
    fl  = chaos && ($urandom_range(0, 19) == 0);
    tgt = 32'($urandom_range(0, 1023)) << 2;
    id_stall = st; flush = fl; imem_ack = 1'b0;
    #1;
    if (m_busy) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_dropped: got req=%0b want 1 (addr %h outstanding)", imem_req, m_addr); end
    end
    if (imem_req === 1'b1) begin
      if (!m_busy) begin
        m_busy = 1'b1; m_addr = imem_addr; m_lat = int'($urandom_range(0, 3));
      end else begin
        checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL addr_stable: got %h want %h", imem_addr, m_addr); end
      end
      imem_ack   = (m_lat == 0);
      imem_rdata = imem_ack ? f_mem(m_addr) : $urandom;
    end
    #1;
    pv = if_valid; ppc = if_pc; pinst = if_inst; pstall = pc_stall;
    if (pv === 1'b1 && !st && !fl) begin
      checks++;
      if (ppc !== exp_pc || pinst !== f_mem(exp_pc)) begin
        errors++; $display("FAIL stream: got pc=%h inst=%h want pc=%h inst=%h", ppc, pinst, exp_pc, f_mem(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    if (imem_ack) m_busy = 1'b0;
    else if (m_busy) m_lat--;
    @(posedge clk); #1;
    if (pstall === 1'b0) pc = fl ? tgt : pc + 32'd4;
    if (fl) exp_pc = tgt;
  endtask

  task automatic test_random();
    clrn = 1'b0; id_stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; pc = 32'h0;
    m_busy = 1'b0; m_lat = 0; exp_pc = 32'h0; n_cons = 0;
    @(posedge clk); #1; clrn = 1'b1;
    for (int i = 0; i < 1500; i++) rand_cycle(1'b1);
    for (int i = 0; i < 20; i++) rand_cycle(1'b0);
    checks++; if (n_cons < 100) begin errors++; $display("FAIL progress: got %0d instructions want >= 100", n_cons); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_in_wait();
    test_flush_drain();
    test_flush_stall_ack();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
